// File: rtl/world_tile_ram.sv
// rtl/world_tile_ram.sv - mutable world tile map: ROM init copy, pixel read port, tile-change command queue
module world_tile_ram #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int IDX_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int Q_IDX      = 6,
    parameter int USED_IDX   = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [12:0]      rom_addr,
    input  logic [IDX_W-1:0] rom_data,
    input  logic [12:0]      rd_addr,
    output logic [IDX_W-1:0] rd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [5:0]       cmd_col,
    input  logic [4:0]       cmd_row,
    input  logic [IDX_W-1:0] cmd_idx,
    output logic             busy,
    output logic             bump_hit,
    output logic             cmd_err
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [12:0]      MAP_END  = 13'(DEPTH);
    localparam logic [5:0]       COLS_L   = 6'(COLS);
    localparam logic [4:0]       ROWS_L   = 5'(ROWS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_CHK} state_t;

    typedef struct packed {
        logic             op;
        logic [5:0]       col;
        logic [4:0]       row;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    state_t           state_q, state_d;
    logic [12:0]      init_cnt_q, init_cnt_d;
    cmd_t             fifo_q [FIFO_DEPTH];
    cmd_t             fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    cmd_t             cur_q, cur_d;
    logic [IDX_W-1:0] rd_data_q, rd_data_d, chk_data_q, chk_data_d;
    logic             bump_hit_q, bump_hit_d, cmd_err_q, cmd_err_d;

    logic [IDX_W-1:0] mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [IDX_W-1:0] mem_wdata;

    logic             push, pop, head_ok;
    cmd_t             head, cmd_in;
    logic [AW-1:0]    cur_addr;

    assign busy      = (state_q == S_INIT);
    assign cmd_ready = !busy && (fill_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (fill_q != '0);
    assign head      = fifo_q[rd_ptr_q];
    assign head_ok   = (head.col < COLS_L) && (head.row < ROWS_L);
    assign cmd_in    = '{op: cmd_op, col: cmd_col, row: cmd_row, idx: cmd_idx};
    // Only ever used for in-range commands, so the narrowing after the 13-bit sum is lossless
    assign cur_addr  = AW'(13'(cur_q.col) + 13'(cur_q.row) * 13'(COLS));
    assign rom_addr  = (init_cnt_q < MAP_END) ? init_cnt_q : MAP_END - 13'd1;
    assign rd_data   = rd_data_q;
    assign bump_hit  = bump_hit_q;
    assign cmd_err   = cmd_err_q;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_cnt_q == MAP_END) state_d = S_IDLE;
            S_IDLE:  if (pop && head_ok) state_d = head.op ? S_RD : S_WR;
            S_WR:    state_d = S_IDLE;
            S_RD:    state_d = S_CHK;
            S_CHK:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        init_cnt_d = init_cnt_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cur_d      = cur_q;
        chk_data_d = chk_data_q;
        bump_hit_d = 1'b0;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        rd_data_d  = (busy || rd_addr >= MAP_END) ? '0 : mem[rd_addr[AW-1:0]];

        if (push) begin
            fifo_d[wr_ptr_q] = cmd_in;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            cur_d     = head;
            cmd_err_d = !head_ok;
        end
        fill_d = fill_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_INIT: begin
                // ROM data trails its address by one cycle, so write the previous address
                if (init_cnt_q != 13'd0) begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(init_cnt_q - 13'd1);
                    mem_wdata = rom_data;
                end
                if (init_cnt_q != MAP_END) init_cnt_d = init_cnt_q + 13'd1;
            end
            S_WR: begin
                mem_we    = 1'b1;
                mem_waddr = cur_addr;
                mem_wdata = cur_q.idx;
            end
            S_RD: chk_data_d = mem[cur_addr];
            S_CHK: begin
                if (chk_data_q == IDX_W'(Q_IDX)) begin
                    mem_we     = 1'b1;
                    mem_waddr  = cur_addr;
                    mem_wdata  = IDX_W'(USED_IDX);
                    bump_hit_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            init_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rd_data_q  <= '0;
            bump_hit_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rd_data_q  <= rd_data_d;
            bump_hit_q <= bump_hit_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        fifo_q     <= fifo_d;
        cur_q      <= cur_d;
        chk_data_q <= chk_data_d;
    end

    // Single write port; both reads sample before the write, giving read-before-write on collision
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) mem[mem_waddr] <= mem_wdata;
    end

endmodule
